hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, multiply/divide stall length in cycles (legal 2..15).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports IF_ID_Rs, IF_ID_Rt, input, 3 each: source registers of the instruction in ID.
REQ-005 SHALL have ports IF_ID_uses_rs, IF_ID_uses_rt, input, 1 each: the ID instruction actually reads Rs or Rt.
REQ-006 SHALL have ports ID_EX_write_reg (input, 3) and ID_EX_mem_read (input, 1): the EX-stage load and its destination.
REQ-007 SHALL have port branch_taken, input, 1: the EX-stage branch resolved taken.
REQ-008 SHALL have port md_start, input, 1: the EX-stage instruction is multiply/divide.
REQ-009 SHALL have port perf_clear, input, 1: synchronous clear of stall_cycles.
REQ-010 SHALL have outputs PC_write, IF_ID_write, ID_EX_write, 1 each, active-high register-update enables.
REQ-011 SHALL have outputs IF_ID_flush, ID_EX_bubble, EX_MEM_bubble, 1 each, active-high inserts of a NOP into that register.
REQ-012 SHALL have outputs md_busy (1) and stall_cycles (16, saturating count of cycles with PC_write=0).

Function
REQ-013 SHALL define load_use = ID_EX_mem_read & (ID_EX_write_reg!=0) & ((uses_rs & Rs match) | (uses_rt & Rt match)).
REQ-014 SHALL implement FSM states RUN and MD_BUSY with a 4-bit down-counter md_cnt.
REQ-015 In RUN with branch_taken=1: IF_ID_flush=1, ID_EX_bubble=1, all write enables=1; md_start and load_use are ignored.
REQ-016 In RUN, otherwise, with md_start=1 and md_skip=0: PC_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1, ID_EX_bubble=0; next state MD_BUSY, md_cnt<=MD_LATENCY-1.
REQ-017 In RUN, otherwise, with load_use=1: PC_write=IF_ID_write=0, ID_EX_bubble=1, ID_EX_write=1.
REQ-018 In RUN with no event: all enables=1, all flush/bubble outputs=0.
REQ-019 In MD_BUSY: outputs as in REQ-016, md_busy=1, md_cnt decrements, branch_taken is ignored, and the FSM returns to RUN on the edge where md_cnt==1.
REQ-020 md_skip SHALL be a register set on the MD_BUSY-to-RUN edge and cleared after one cycle; while set, md_start is ignored so the held instruction does not retrigger; total stall = MD_LATENCY cycles.
REQ-021 stall_cycles SHALL increment when PC_write=0, hold at 16'hFFFF, and clear when perf_clear=1 (clear wins over increment).
REQ-022 All flush, bubble and enable outputs SHALL be combinational from state and inputs; md_busy SHALL be decoded from state.

Reset
REQ-023 On reset assertion: state=RUN, md_cnt=0, md_skip=0, stall_cycles=0, md_busy=0.
REQ-024 While reset=1: PC_write=IF_ID_write=ID_EX_write=0, IF_ID_flush=ID_EX_bubble=EX_MEM_bubble=1, stall_cycles not incremented.
REQ-025 Reset asserted mid-MD_BUSY SHALL abort the stall immediately; the first cycle after release is RUN.

Configuration
REQ-026 Macro HAZARD_MULDIV_EN SHALL compile in MD_BUSY, md_cnt and md_skip.
REQ-027 Without HAZARD_MULDIV_EN: md_start is ignored, md_busy=0 constant, EX_MEM_bubble=0 outside reset, ID_EX_write=1 outside reset.

Structure
REQ-028 A shared package SHALL hold the state enum, register-address width (3), data width (16) and the zero-register constant.
REQ-029 The block SHALL be a single module; the load-use comparator MAY be the sub-module load_use_detect.

Verification
REQ-030 Load to R3 in EX, ID reads Rs=R3 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles=1.
REQ-031 Load to R0 in EX, ID Rs=R0 -> no stall; also load to R3 with uses_rs=0 -> no stall.
REQ-032 md_start with MD_LATENCY=4 -> 4 cycles PC_write=0 and EX_MEM_bubble=1, md_busy=1 for 3 cycles; md_start held one further cycle -> ignored.
REQ-033 branch_taken with load_use=1 and md_start=1 -> flush and bubble only, PC_write=1, state stays RUN.
REQ-034 Reset mid-MD_BUSY (md_cnt=2) -> md_busy=0 immediately; after release, RUN with all counters 0.
REQ-035 Hold load_use for 70000 cycles -> stall_cycles=16'hFFFF; then perf_clear=1 -> 0 on next edge.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall controller.
// HAZARD_MULDIV_EN (see hazard_stall_unit.sv) enables the multiply/divide stall FSM.
package hazard_stall_unit_pkg;

   localparam int unsigned REG_AW   = 3;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned MD_CNT_W = 4;

   localparam logic [REG_AW-1:0] ZERO_REG = '0;

   localparam logic [0:0] S_RUN     = 1'b0;
   localparam logic [0:0] S_MD_BUSY = 1'b1;

   typedef enum logic [0:0] {
      RUN     = S_RUN,
      MD_BUSY = S_MD_BUSY
   } state_e;

   // Pipeline register controls driven by the unit each cycle.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_bubble;
   } hazard_ctl_t;

   localparam hazard_ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam hazard_ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam hazard_ctl_t CTL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam hazard_ctl_t CTL_MD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam hazard_ctl_t CTL_LOAD   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == '1) ? v : v + DATA_W'(1);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Load-use comparator: EX-stage load whose destination is read by the ID instruction.
module load_use_detect
   import hazard_stall_unit_pkg::*;
(
   input  logic [REG_AW-1:0] rs_i,
   input  logic [REG_AW-1:0] rt_i,
   input  logic              uses_rs_i,
   input  logic              uses_rt_i,
   input  logic [REG_AW-1:0] ex_write_reg_i,
   input  logic              ex_mem_read_i,
   output logic              load_use_o
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = uses_rs_i && (rs_i == ex_write_reg_i);
   assign rt_hit = uses_rt_i && (rt_i == ex_write_reg_i);

   // Writes to the zero register are discarded, so they never create a hazard.
   assign load_use_o = ex_mem_read_i && (ex_write_reg_i != ZERO_REG) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use stall, branch flush, multiply/divide stall.
// Define HAZARD_MULDIV_EN to build the MD_BUSY state, md_cnt and md_skip.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] IF_ID_Rs,
   input  logic [REG_AW-1:0] IF_ID_Rt,
   input  logic              IF_ID_uses_rs,
   input  logic              IF_ID_uses_rt,
   input  logic [REG_AW-1:0] ID_EX_write_reg,
   input  logic              ID_EX_mem_read,
   input  logic              branch_taken,
   input  logic              md_start,
   input  logic              perf_clear,
   output logic              PC_write,
   output logic              IF_ID_write,
   output logic              ID_EX_write,
   output logic              IF_ID_flush,
   output logic              ID_EX_bubble,
   output logic              EX_MEM_bubble,
   output logic              md_busy,
   output logic [DATA_W-1:0] stall_cycles
);

   localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);

   logic              load_use;
   hazard_ctl_t       ctl;
   logic [DATA_W-1:0] stall_cnt_q;
   logic [DATA_W-1:0] stall_cnt_d;

   load_use_detect u_load_use_detect (
      .rs_i           (IF_ID_Rs),
      .rt_i           (IF_ID_Rt),
      .uses_rs_i      (IF_ID_uses_rs),
      .uses_rt_i      (IF_ID_uses_rt),
      .ex_write_reg_i (ID_EX_write_reg),
      .ex_mem_read_i  (ID_EX_mem_read),
      .load_use_o     (load_use)
   );

`ifdef HAZARD_MULDIV_EN
   state_e              state_q;
   state_e              state_d;
   logic [MD_CNT_W-1:0] md_cnt_q;
   logic [MD_CNT_W-1:0] md_cnt_d;
   logic                md_skip_q;
   logic                md_skip_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         md_cnt_q  <= '0;
         md_skip_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         md_cnt_q  <= md_cnt_d;
         md_skip_q <= md_skip_d;
      end
   end

   // md_skip masks md_start for the one cycle after a stall so the held op does not retrigger.
   always_comb begin
      ctl       = CTL_RUN;
      state_d   = state_q;
      md_cnt_d  = md_cnt_q;
      md_skip_d = 1'b0;
      if (reset) begin
         ctl = CTL_RESET;
      end else begin
         case (state_q)
            MD_BUSY: begin
               ctl      = CTL_MD;
               md_cnt_d = md_cnt_q - MD_CNT_W'(1);
               if (md_cnt_q == MD_CNT_W'(1)) begin
                  state_d   = RUN;
                  md_skip_d = 1'b1;
               end
            end
            default: begin
               if (branch_taken) begin
                  ctl = CTL_BRANCH;
               end else if (md_start && !md_skip_q) begin
                  ctl      = CTL_MD;
                  state_d  = MD_BUSY;
                  md_cnt_d = MD_RELOAD;
               end else if (load_use) begin
                  ctl = CTL_LOAD;
               end
            end
         endcase
      end
   end

   assign md_busy = (state_q == MD_BUSY);
`else
   logic [MD_CNT_W:0] unused_md;

   assign unused_md = {md_start, MD_RELOAD};

   always_comb begin
      ctl = CTL_RUN;
      if (reset) begin
         ctl = CTL_RESET;
      end else if (branch_taken) begin
         ctl = CTL_BRANCH;
      end else if (load_use) begin
         ctl = CTL_LOAD;
      end
   end

   assign md_busy = 1'b0;
`endif

   assign PC_write      = ctl.pc_write;
   assign IF_ID_write   = ctl.if_id_write;
   assign ID_EX_write   = ctl.id_ex_write;
   assign IF_ID_flush   = ctl.if_id_flush;
   assign ID_EX_bubble  = ctl.id_ex_bubble;
   assign EX_MEM_bubble = ctl.ex_mem_bubble;

   // Saturating count of cycles with the PC frozen; clear has priority.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (perf_clear) begin
         stall_cnt_d = '0;
      end else if (!ctl.pc_write) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit against a cycle-count reference model.
// Follows HAZARD_MULDIV_EN to decide whether multiply/divide stalls are expected.
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   localparam int unsigned LAT = 4;
`ifdef HAZARD_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_AW-1:0] IF_ID_Rs, IF_ID_Rt, ID_EX_write_reg;
   logic              IF_ID_uses_rs, IF_ID_uses_rt, ID_EX_mem_read;
   logic              branch_taken, md_start, perf_clear;
   logic              PC_write, IF_ID_write, ID_EX_write;
   logic              IF_ID_flush, ID_EX_bubble, EX_MEM_bubble, md_busy;
   logic [DATA_W-1:0] stall_cycles;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: remaining MD stall cycles, skip flag, stall counter.
   int          m_left = 0;
   bit          m_skip = 1'b0;
   int unsigned m_cnt  = 0;

   hazard_stall_unit #(.MD_LATENCY(LAT)) dut (
      .clk             (clk),
      .reset           (reset),
      .IF_ID_Rs        (IF_ID_Rs),
      .IF_ID_Rt        (IF_ID_Rt),
      .IF_ID_uses_rs   (IF_ID_uses_rs),
      .IF_ID_uses_rt   (IF_ID_uses_rt),
      .ID_EX_write_reg (ID_EX_write_reg),
      .ID_EX_mem_read  (ID_EX_mem_read),
      .branch_taken    (branch_taken),
      .md_start        (md_start),
      .perf_clear      (perf_clear),
      .PC_write        (PC_write),
      .IF_ID_write     (IF_ID_write),
      .ID_EX_write     (ID_EX_write),
      .IF_ID_flush     (IF_ID_flush),
      .ID_EX_bubble    (ID_EX_bubble),
      .EX_MEM_bubble   (EX_MEM_bubble),
      .md_busy         (md_busy),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] rs, input logic urs, input logic [2:0] rt, input logic urt,
                        input logic [2:0] wr, input logic mr, input logic br, input logic md,
                        input logic pc);
      IF_ID_Rs = rs; IF_ID_uses_rs = urs; IF_ID_Rt = rt; IF_ID_uses_rt = urt;
      ID_EX_write_reg = wr; ID_EX_mem_read = mr; branch_taken = br; md_start = md;
      perf_clear = pc;
   endtask

   // Check one cycle against the model, advance the model, then cross the clock edge.
   task automatic step(input string tag);
      logic [6:0]  exp_ctl;
      logic [15:0] exp_cnt;
      bit          lu;
      #1;
      lu = ID_EX_mem_read && (ID_EX_write_reg != 3'd0) &&
           ((IF_ID_uses_rs && IF_ID_Rs == ID_EX_write_reg) ||
            (IF_ID_uses_rt && IF_ID_Rt == ID_EX_write_reg));
      // Order: PC_write IF_ID_write ID_EX_write | IF_ID_flush ID_EX_bubble EX_MEM_bubble | md_busy
      if (reset) begin
         exp_ctl = 7'b000_111_0;
         exp_cnt = 16'h0000;
      end else begin
         exp_cnt = 16'(m_cnt);
         if (MD_EN && m_left > 0)                     exp_ctl = 7'b000_001_1;
         else if (branch_taken)                       exp_ctl = 7'b111_110_0;
         else if (MD_EN && md_start && !m_skip)       exp_ctl = 7'b000_001_0;
         else if (lu)                                 exp_ctl = 7'b001_010_0;
         else                                         exp_ctl = 7'b111_000_0;
      end
      chk({tag, ".ctl"}, 32'({PC_write, IF_ID_write, ID_EX_write, IF_ID_flush,
                              ID_EX_bubble, EX_MEM_bubble, md_busy}), 32'(exp_ctl));
      chk({tag, ".cnt"}, 32'(stall_cycles), 32'(exp_cnt));
      if (reset) begin
         m_left = 0; m_skip = 1'b0; m_cnt = 0;
      end else begin
         if (perf_clear)                              m_cnt = 0;
         else if (!exp_ctl[6] && m_cnt < 65535)       m_cnt = m_cnt + 1;
         if (MD_EN && m_left > 0) begin
            m_skip = (m_left == 1);
            m_left = m_left - 1;
         end else if (MD_EN && !branch_taken && md_start && !m_skip) begin
            m_left = int'(LAT) - 1;
            m_skip = 1'b0;
         end else begin
            m_skip = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy_seen;
      reset = 1'b1;
      drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("reset0");
      step("reset1");
      reset = 1'b0;
      step("idle");

      // Load to R3, ID reads R3 -> single stall cycle.
      drive(3'd3, 1'b1, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_rs");
      drive(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_cnt1", 32'(stall_cycles), 32'd1);
      step("after_lu");
      drive(3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_r0");
      drive(3'd3, 1'b0, 3'd4, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_nors");
      drive(3'd6, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_rt");

      // Branch overrides load-use and md_start.
      drive(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      step("br_all");
      chk("br_nobusy", 32'(md_busy), 32'd0);

      // md_start held for the full stall plus one more cycle.
      drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("pclr");
      drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      busy_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step($sformatf("md%0d", i));
         busy_seen += int'(md_busy);
      end
      chk("md_busy_cycles", 32'(busy_seen), MD_EN ? 32'd3 : 32'd0);
      chk("md_stall_total", 32'(stall_cycles), MD_EN ? 32'(LAT) : 32'd0);
      md_start = 1'b0;
      step("md_done");

      // Reset in the middle of a multiply/divide stall.
      md_start = 1'b1;
      step("mdr0");
      md_start = 1'b0;
      step("mdr1");
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_busy", 32'(md_busy), 32'd0);
      chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
      step("mdr_rst");
      reset = 1'b0;
      step("mdr_rel");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 19) == 0));
         reset = ($urandom_range(0, 39) == 0);
         step($sformatf("rnd%0d", i));
      end

      // Saturation of the stall counter, then clear with load-use still present.
      reset = 1'b1;
      drive(3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step("sat_rst");
      reset = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      m_cnt = (m_cnt + 70000 > 65535) ? 65535 : m_cnt + 70000;
      chk("sat_ffff", 32'(stall_cycles), 32'h0000_FFFF);
      perf_clear = 1'b1;
      step("sat_clr");
      chk("sat_cleared", 32'(stall_cycles), 32'd0);
      perf_clear = 1'b0;
      step("sat_resume");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
